// File: rtl/oam_eval_pkg.sv
// Shared definitions for the per-scanline sprite evaluation controller.
// Holds the controller state encoding, the OAM / secondary-OAM geometry
// constants and a helper that forms an OAM byte address from a sprite
// index and byte offset.
package oam_eval_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        CHECK  = 3'd2,
        COPY   = 3'd3,
        FINISH = 3'd4
    } state_e;

    localparam int         OAM_BYTES     = 256;
    localparam int         SOAM_BYTES    = 32;
    localparam logic [7:0] CLEAR_VAL     = 8'hFF;
    localparam int         BYTES_PER_SPR = 4;

    // Byte address of byte b (0..3) of sprite idx (0..63) in OAM.
    function automatic logic [7:0] spr_byte_addr(input logic [5:0] idx, input logic [1:0] b);
        return {idx, b};
    endfunction

endpackage

// File: rtl/oam_y_in_range.sv
// Sprite Y range test, shared with the renderer's row-offset logic.
// Ports:
//   scanline  in  8  line being evaluated
//   y         in  8  sprite top line (OAM byte 0)
//   height    in  8  sprite height in lines
//   in_range  out 1  scanline lies within [y, y+height-1], no wrap
// Purely combinational.
module oam_y_in_range (
    input  logic [7:0] scanline,
    input  logic [7:0] y,
    input  logic [7:0] height,
    output logic       in_range
);

    logic [8:0] diff_s;

    // 9-bit difference: the borrow bit rejects sprites that start below the line,
    // so a sprite near the bottom of the screen never wraps to the top.
    always_comb begin
        diff_s   = {1'b0, scanline} - {1'b0, y};
        in_range = (diff_s[8] == 1'b0) && (diff_s[7:0] < height);
    end

endmodule

// File: rtl/oam_sprite_eval.sv
// Per-scanline sprite evaluation controller.
// On start: fills the 32-byte secondary OAM with 0xFF, scans all OAM sprites
// for those covering the sampled scanline, and copies up to MAX_SPR of them
// (4 bytes each) into secondary OAM.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sprite_16           (only with OAM_SPR_8X16_EN) 8x16 mode, sampled on start
//   start, scanline     begin evaluation of scanline (ignored while busy)
//   oam_addr/oam_data   OAM read port, data valid in the same cycle
//   soam_we/addr/wdata  secondary OAM write port, written on rising edge
//   busy, done          evaluation in progress / one-cycle completion pulse
//   spr_count           sprites copied; overflow: more than MAX_SPR in range
//   spr0_inl            sprite 0 is in range on this line
// Optional feature macro: OAM_SPR_8X16_EN (adds sprite_16, height 16 when set).
module oam_sprite_eval
    import oam_eval_pkg::*;
#(
    parameter int NUM_SPR = 64,
    parameter int MAX_SPR = 8,
    parameter int SPR_H   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef OAM_SPR_8X16_EN
    input  logic       sprite_16,
`endif
    input  logic       start,
    input  logic [7:0] scanline,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_data,
    output logic       soam_we,
    output logic [4:0] soam_addr,
    output logic [7:0] soam_wdata,
    output logic       busy,
    output logic       done,
    output logic [3:0] spr_count,
    output logic       overflow,
    output logic       spr0_inl
);

    localparam int NW = $clog2(NUM_SPR);

    state_e          state_q, state_d;
    logic [7:0]      line_q, line_d;
    logic [7:0]      height_q, height_d;
    logic [NW-1:0]   n_q, n_d;
    logic [1:0]      b_q, b_d;
    logic [4:0]      clr_q, clr_d;
    logic [3:0]      spr_count_q, spr_count_d;
    logic            overflow_q, overflow_d;
    logic            spr0_q, spr0_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      start_height_s;
    logic            in_range_s;
    logic            last_spr_s;
    logic            slot_free_s;

    oam_y_in_range u_y_in_range (
        .scanline (line_q),
        .y        (oam_data),
        .height   (height_q),
        .in_range (in_range_s)
    );

    // Height selected at start time.
    always_comb begin
`ifdef OAM_SPR_8X16_EN
        if (sprite_16) begin
            start_height_s = 8'd16;
        end else begin
            start_height_s = 8'(SPR_H);
        end
`else
        start_height_s = 8'(SPR_H);
`endif
    end

    // Next-state and next-register computation for the evaluation FSM.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        height_d    = height_q;
        n_d         = n_q;
        b_d         = b_q;
        clr_d       = clr_q;
        spr_count_d = spr_count_q;
        overflow_d  = overflow_q;
        spr0_d      = spr0_q;
        last_spr_s  = (n_q == NW'(NUM_SPR - 1));
        slot_free_s = (spr_count_q < 4'(MAX_SPR));
        case (state_q)
            IDLE: begin
                if (start) begin
                    line_d      = scanline;
                    height_d    = start_height_s;
                    spr_count_d = 4'd0;
                    overflow_d  = 1'b0;
                    spr0_d      = 1'b0;
                    clr_d       = 5'd0;
                    state_d     = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (clr_q == 5'(SOAM_BYTES - 1)) begin
                    n_d     = '0;
                    state_d = CHECK;
                end else begin
                    clr_d = clr_q + 5'd1;
                end
            end
            CHECK: begin
                if (in_range_s) begin
                    if (slot_free_s) begin
                        if (n_q == '0) begin
                            spr0_d = 1'b1;
                        end else begin
                            spr0_d = spr0_q;
                        end
                        b_d     = 2'd1;
                        state_d = COPY;
                    end else begin
                        // Ninth candidate: flag it and stop scanning.
                        overflow_d = 1'b1;
                        state_d    = FINISH;
                    end
                end else if (last_spr_s) begin
                    state_d = FINISH;
                end else begin
                    n_d = n_q + NW'(1);
                end
            end
            COPY: begin
                if (b_q == 2'd3) begin
                    b_d         = 2'd0;
                    spr_count_d = spr_count_q + 4'd1;
                    if (last_spr_s) begin
                        state_d = FINISH;
                    end else begin
                        n_d     = n_q + NW'(1);
                        state_d = CHECK;
                    end
                end else begin
                    b_d = b_q + 2'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CLEAR) || (state_d == CHECK) || (state_d == COPY);
        done_d = (state_d == FINISH);
    end

    // FSM and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            line_q      <= 8'd0;
            height_q    <= 8'd0;
            n_q         <= '0;
            b_q         <= 2'd0;
            clr_q       <= 5'd0;
            spr_count_q <= 4'd0;
            overflow_q  <= 1'b0;
            spr0_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            height_q    <= height_d;
            n_q         <= n_d;
            b_q         <= b_d;
            clr_q       <= clr_d;
            spr_count_q <= spr_count_d;
            overflow_q  <= overflow_d;
            spr0_q      <= spr0_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Memory-port decode: addresses come from state registers, write data is
    // passed straight through from OAM so each byte lands in one cycle.
    always_comb begin
        oam_addr   = 8'd0;
        soam_we    = 1'b0;
        soam_addr  = 5'd0;
        soam_wdata = 8'd0;
        case (state_q)
            CLEAR: begin
                soam_we    = 1'b1;
                soam_addr  = clr_q;
                soam_wdata = CLEAR_VAL;
            end
            CHECK: begin
                oam_addr   = spr_byte_addr(6'(n_q), 2'd0);
                soam_we    = in_range_s && (spr_count_q < 4'(MAX_SPR));
                soam_addr  = {spr_count_q[2:0], 2'd0};
                soam_wdata = oam_data;
            end
            COPY: begin
                oam_addr   = spr_byte_addr(6'(n_q), b_q);
                soam_we    = 1'b1;
                soam_addr  = {spr_count_q[2:0], b_q};
                soam_wdata = oam_data;
            end
            default: begin
                oam_addr = 8'd0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign spr_count = spr_count_q;
    assign overflow  = overflow_q;
    assign spr0_inl  = spr0_q;

endmodule

// File: doc/oam_sprite_eval.md
Name: oam_sprite_eval

Overview:
- Per-scanline sprite evaluation controller for the 256-byte sprite memory (OAM: 64 sprites × 4 bytes, combinational read: Y, tile, attr, X).
- On each `start` it does three things:
  - clears an external 32-byte secondary OAM to 0xFF;
  - scans all sprites for those whose Y range covers `scanline`;
  - copies up to MAX_SPR of them into secondary OAM for the sprite renderer.
- Reports the found count, an overflow flag and sprite-0 presence.

Parameters:
- NUM_SPR, 64: sprites in OAM (OAM address width 8).
- MAX_SPR, 8: secondary OAM slots (secondary address width 5).
- SPR_H, 8: sprite height in lines.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin evaluation; ignored while busy
- scanline  in  8  line to evaluate; sampled on start
- oam_addr  out  8  OAM read address
- oam_data  in  8  OAM data; valid in the same cycle as oam_addr
- soam_we  out  1  secondary OAM write enable
- soam_addr  out  5  secondary OAM write address
- soam_wdata  out  8  secondary OAM write data
- busy  out  1  evaluation in progress
- done  out  1  one-cycle pulse: evaluation finished
- spr_count  out  4  sprites copied (0..MAX_SPR)
- overflow  out  1  more than MAX_SPR sprites in range
- spr0_inl  out  1  sprite 0 in range on this line

Behaviour:
- Reset values: state IDLE; every output 0, including oam_addr and soam_addr. Reset mid-operation aborts immediately and no done pulse is issued.
- Write timing: soam_we/addr/wdata are decoded from state registers plus oam_data. The target writes on the rising edge while soam_we=1.
- State IDLE:
  - On start: latch scanline, clear spr_count/overflow/spr0_inl, set busy, go to CLEAR.
- State CLEAR (32 cycles):
  - soam_we=1, soam_addr=0..31, soam_wdata=0xFF.
  - Then go to CHECK with n=0.
- State CHECK (1 cycle per sprite):
  - oam_addr = 4n; diff = {0,scanline} − {0,oam_data} (9 bits); in-range = (diff[8]==0) && (diff[7:0] < H).
  - In range and spr_count < MAX_SPR:
    - write Y: soam_we=1, soam_addr = 4·spr_count, wdata = oam_data;
    - if n==0, set spr0_inl;
    - go to COPY with b=1.
  - In range and spr_count == MAX_SPR: set overflow, go to FINISH (scan terminates early).
  - Not in range: if n == NUM_SPR−1 go to FINISH, else n+1 and stay in CHECK.
- State COPY (3 cycles, b=1..3):
  - oam_addr = 4n+b; soam_addr = 4·spr_count+b; wdata = oam_data; soam_we=1.
  - After b=3: increment spr_count. If n == NUM_SPR−1 go to FINISH, else n+1 and go to CHECK.
- State FINISH: done=1 for one cycle, busy falls to 0, go to IDLE. spr_count, overflow and spr0_inl hold until the next start.
- Latency without overflow: busy high for exactly 32 + NUM_SPR + 3·spr_count cycles; done in the following cycle. Worst case 32+64+24 = 120.
- Y=0xFF is in range only for scanline 0xFF (diff=0).
- The address counter never wraps past 0xFF.
- start asserted in the same cycle as done is ignored; start is accepted only in IDLE.

Optional Feature:
- Macro: OAM_SPR_8X16_EN.
- Defined: adds input port sprite_16 (1 bit), sampled on start. H = sprite_16 ? 16 : SPR_H.
- Undefined: the port is absent and H = SPR_H.
- Comparator width is unchanged in both cases.

Decomposition:
- Package oam_eval_pkg holds:
  - state encoding (IDLE, CLEAR, CHECK, COPY, FINISH);
  - constants OAM_BYTES=256, SOAM_BYTES=32, CLEAR_VAL=8'hFF, BYTES_PER_SPR=4.
- One natural sub-module: oam_y_in_range. Purely combinational: inputs scanline, y, height; output in_range. Shared with the renderer's row-offset logic.

Test Plan (OAM loaded with the Pac-Man sprite image, H=8 unless stated):
- scanline=0xAC → sprites 0,1 (Y=0xAB) copied. soam[0..7] = AB 02 00 4F AB 01 00 57, soam[8..31]=FF; spr_count=2, spr0_inl=1, overflow=0; busy 102 cycles.
- scanline=0x70 → sprites 0x08,0x09,0x0C,0x0D,0x10,0x11 copied. spr_count=6, spr0_inl=0; soam[4..7] = 6F 18 41 5C.
- scanline=0x78, H=8 → only the Y=0x77 sprites (0x0A,0x0B,0x0E,0x0F,0x12,0x13) copied; spr_count=6. With OAM_SPR_8X16_EN and sprite_16=1 → 12 candidates: spr_count=8, overflow=1, done early.
- scanline=3 → sprites 0x18.. (all-zero bytes) fill 8 slots with 00. overflow=1 on sprite 0x20; spr0_inl=0.
- start pulse during busy, then rst_n low mid-COPY → second start ignored; on reset all outputs 0 with no done pulse. A new start after reset completes normally.
- scanline=0xFF → sprites 0x14..0x17 (Y=0xFF) in range: spr_count=4, soam[0..3] = FF 4C 00 FF.
